// File: rtl/minirisc_pkg.sv
// Shared state encodings and opcode constants for the minirisc control path.
package minirisc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_ALU   = 4'd1;
    localparam logic [3:0] OP_ADDI  = 4'd2;
    localparam logic [3:0] OP_COMPI = 4'd3;
    localparam logic [3:0] OP_LW    = 4'd4;
    localparam logic [3:0] OP_SW    = 4'd5;
    localparam logic [3:0] OP_BEQ   = 4'd6;
    localparam logic [3:0] OP_BNE   = 4'd7;
    localparam logic [3:0] OP_BLT   = 4'd8;
    localparam logic [3:0] OP_BGE   = 4'd9;
    localparam logic [3:0] OP_JMP   = 4'd10;
    localparam logic [3:0] OP_BL    = 4'd11;
    localparam logic [3:0] OP_BLTU  = 4'd12;
    localparam logic [3:0] OP_BGEU  = 4'd13;
    localparam logic [3:0] OP_DIFF  = 4'd14;
    localparam logic [3:0] OP_HALT  = 4'd15;

endpackage

// File: rtl/exec_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control strobes.
// Optional HALT state enabled by defining MINIRISC_HALT_EN.
module exec_sequencer
    import minirisc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic       branch_taken,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    output logic       imem_req,
    output logic       ir_we,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       rf_we,
    output logic       pc_we,
    output logic       pc_src,
    output logic       retire,
    output logic [2:0] state,
    output logic       halted
);

    state_t cur, nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= ST_FETCH;
        else        cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        case (cur)
            ST_FETCH:  if (imem_ack) nxt = ST_DECODE;
            ST_DECODE: nxt = ST_EXEC;
            ST_EXEC: begin
                case (opcode)
                    OP_LW, OP_SW:                               nxt = ST_MEM;
                    OP_ALU, OP_ADDI, OP_COMPI, OP_BL, OP_DIFF:  nxt = ST_WB;
`ifdef MINIRISC_HALT_EN
                    OP_HALT:                                    nxt = ST_HALT;
`endif
                    default:                                    nxt = ST_FETCH;
                endcase
            end
            ST_MEM:    if (dmem_ack) nxt = (opcode == OP_LW) ? ST_WB : ST_FETCH;
            ST_WB:     nxt = ST_FETCH;
`ifdef MINIRISC_HALT_EN
            ST_HALT:   nxt = ST_HALT;
`endif
            default:   nxt = ST_FETCH;
        endcase
    end

    // Outputs are gated by rst_n so requests and strobes drop the instant reset asserts.
    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        pc_src   = 1'b0;
        retire   = 1'b0;
        if (rst_n) begin
            case (cur)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ack;
                end
                ST_EXEC: begin
                    case (opcode)
                        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_JMP, OP_BLTU, OP_BGEU: begin
                            pc_we  = 1'b1;
                            pc_src = branch_taken;
                            retire = 1'b1;
                        end
                        OP_NOP: begin
                            pc_we  = 1'b1;
                            retire = 1'b1;
                        end
                        OP_HALT: begin
`ifdef MINIRISC_HALT_EN
                            retire = 1'b1;
`else
                            pc_we  = 1'b1;
                            retire = 1'b1;
`endif
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (opcode == OP_SW);
                    if (dmem_ack && opcode != OP_LW) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end
                end
                ST_WB: begin
                    rf_we  = 1'b1;
                    pc_we  = 1'b1;
                    pc_src = (opcode == OP_BL);
                    retire = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state = cur;

`ifdef MINIRISC_HALT_EN
    assign halted = rst_n && (cur == ST_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: expected retire records are queued by the
// stimulus and checked by an independent monitor when retire pulses.
module tb_exec_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] opcode = 4'd0;
    logic       branch_taken = 1'b0;
    logic       imem_ack = 1'b0;
    logic       dmem_ack = 1'b0;
    logic       imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_src, retire, halted;
    logic [2:0] state;

    int checks = 0;
    int failures = 0;
    int dwait = 0;

    typedef struct {
        int   lat;
        logic ps;
        logic pw;
        int   rfn;
        int   drn;
        int   dwn;
    } exp_t;

    exp_t sb[$];

    exec_sequencer dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .ir_we(ir_we),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we), .pc_we(pc_we),
        .pc_src(pc_src), .retire(retire), .state(state), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory responder: zero-wait instruction fetch, dwait-cycle data memory.
    initial begin
        int dcnt = 0;
        forever begin
            @(negedge clk);
            imem_ack = imem_req;
            if (dmem_req) begin
                dmem_ack = (dcnt == dwait);
                dcnt++;
            end else begin
                dmem_ack = 1'b0;
                dcnt = 0;
            end
        end
    end

    // Monitor: counts strobes per instruction, compares against the queue on retire.
    initial begin
        int cyc = 0, base = 0, rfn = 0, drn = 0, dwn = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (ir_we) begin
                base = cyc;
                rfn = 0;
                drn = 0;
                dwn = 0;
            end
            if (rf_we)    rfn++;
            if (dmem_req) drn++;
            if (dmem_we)  dwn++;
            chk("req_exclusive", int'(imem_req && dmem_req), 0);
            if (retire) begin
                if (sb.size() == 0) begin
                    chk("unexpected_retire", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("latency", cyc - base, e.lat);
                    chk("pc_src", int'(pc_src), int'(e.ps));
                    chk("pc_we", int'(pc_we), int'(e.pw));
                    chk("rf_we_cycles", rfn, e.rfn);
                    chk("dmem_req_cycles", drn, e.drn);
                    chk("dmem_we_cycles", dwn, e.dwn);
                end
            end
        end
    end

    task automatic run_instr(input logic [3:0] op, input logic bt, input int dw,
                             input int lat, input logic ps, input logic pw,
                             input int rfn, input int drn, input int dwn);
        exp_t e;
        bit got;
        e.lat = lat; e.ps = ps; e.pw = pw; e.rfn = rfn; e.drn = drn; e.dwn = dwn;
        sb.push_back(e);
        opcode = op;
        branch_taken = bt;
        dwait = dw;
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            #1;
            if (retire) got = 1;
        end
        chk($sformatf("retire_seen_op%0d", op), int'(got), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit seen;
        #1;
        chk("rst_state", int'(state), 0);
        chk("rst_imem_req", int'(imem_req), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_strobes", int'({ir_we, rf_we, pc_we, retire, dmem_we, dmem_req, pc_src}), 0);
        repeat (3) @(negedge clk);
        #3 rst_n = 1'b1;
        #1 chk("post_rst_imem_req", int'(imem_req), 1);

        //        op    bt  dw lat ps  pw  rf dr dwe
        run_instr(4'd1, 0, 0, 3, 0, 1, 1, 0, 0);
        run_instr(4'd4, 0, 3, 7, 0, 1, 1, 4, 0);
        run_instr(4'd9, 1, 0, 2, 1, 1, 0, 0, 0);
        run_instr(4'd9, 0, 0, 2, 0, 1, 0, 0, 0);
        run_instr(4'd5, 0, 2, 5, 0, 1, 0, 3, 3);
        run_instr(4'd11, 0, 0, 3, 1, 1, 1, 0, 0);
        run_instr(4'd0, 1, 0, 2, 0, 1, 0, 0, 0);
        run_instr(4'd14, 1, 0, 3, 0, 1, 1, 0, 0);
        run_instr(4'd4, 0, 0, 4, 0, 1, 1, 1, 0);

        // Reset in the middle of a long data-memory wait.
        opcode = 4'd4;
        dwait = 20;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (dmem_req) seen = 1;
        end
        chk("mem_wait_reached", int'(seen), 1);
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midmem_dmem_req", int'(dmem_req), 0);
        chk("midmem_write_strobes", int'({rf_we, dmem_we, pc_we, retire}), 0);
        chk("midmem_state", int'(state), 0);
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        #1;
        chk("release_imem_req", int'(imem_req), 1);
        chk("release_state", int'(state), 0);

        run_instr(4'd3, 0, 0, 3, 0, 1, 1, 0, 0);

`ifdef MINIRISC_HALT_EN
        run_instr(4'd15, 1, 0, 2, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            chk("halt_halted", int'(halted), 1);
            chk("halt_no_imem_req", int'(imem_req), 0);
        end
`else
        run_instr(4'd15, 1, 0, 2, 0, 1, 0, 0, 0);
        #1 chk("nohalt_halted", int'(halted), 0);
        chk("nohalt_fetch", int'(imem_req), 1);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
